// File: rtl/clk_rst_sequencer_pkg.sv
// Shared types and helpers for the PLL lock supervisor / reset sequencer.
package clk_rst_sequencer_pkg;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        FAULT
    } state_t;

    localparam int RETRY_W = 4;

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with asynchronous active-low clear.
module sync_2ff (
    input  logic refclk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clk_rst_sequencer.sv
// PLL lock supervisor and staggered domain reset sequencer.
// Optional lock-loss counter output enabled by CLK_RST_SEQUENCER_LOSS_CNT_EN.
module clk_rst_sequencer
    import clk_rst_sequencer_pkg::*;
#(
    parameter int NUM_PLL             = 2,
    parameter int NUM_DOMAINS         = 4,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int RELEASE_GAP         = 8,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                   refclk,
    input  logic                   rst_n,
    input  logic [NUM_PLL-1:0]     pll_locked,
    input  logic                   force_relock,
    output logic [NUM_PLL-1:0]     pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    output logic                   all_locked,
    output logic                   fault,
    output logic [RETRY_W-1:0]     retry_count
`ifdef CLK_RST_SEQUENCER_LOSS_CNT_EN
    ,
    output logic [15:0]            lock_loss_cnt
`endif
);

    localparam int REL_LAST = (NUM_DOMAINS - 1) * RELEASE_GAP;
    localparam int MAX_A    = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES
                                                                     : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_MAX  = (MAX_A > REL_LAST + 1) ? MAX_A : REL_LAST + 1;
    localparam int CW       = cnt_width(CNT_MAX);

    localparam logic [CW-1:0]      RST_END = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0]      TO_END  = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]      STB_END = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0]      REL_END = CW'(REL_LAST);
    localparam logic [RETRY_W-1:0] RTY_MAX = RETRY_W'(MAX_RETRIES);

    logic [NUM_PLL-1:0] lk_sync;
    logic               lk;

    for (genvar g = 0; g < NUM_PLL; g++) begin : g_sync
        sync_2ff u_sync (
            .refclk (refclk),
            .rst_n  (rst_n),
            .d      (pll_locked[g]),
            .q      (lk_sync[g])
        );
    end

    assign lk = &lk_sync;

    state_t                   state, state_d;
    logic [CW-1:0]            cnt, cnt_d;
    logic [RETRY_W-1:0]       retry_d, retry_inc;
    logic                     pll_rst_d, all_locked_d, fault_d, loss_evt;
    logic [NUM_DOMAINS-1:0]   dom_d;

    assign retry_inc = (retry_count == '1) ? retry_count : retry_count + 1'b1;

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        retry_d  = retry_count;
        loss_evt = 1'b0;
        case (state)
            RESET_PLL: begin
                if (cnt == RST_END) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            WAIT_LOCK: begin
                // lock arriving in the timeout cycle beats the retry
                if (lk) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt == TO_END) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RTY_MAX) ? FAULT : RESET_PLL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            STABLE: begin
                if (!lk) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt == STB_END) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (!lk) begin
                    state_d = RESET_PLL;
                    cnt_d   = '0;
                end else if (cnt == REL_END) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            RUN: begin
                if (!lk) begin
                    state_d  = RESET_PLL;
                    cnt_d    = '0;
                    retry_d  = '0;
                    loss_evt = 1'b1;
                end
            end
            default: ;
        endcase

        if (force_relock) begin
            state_d  = RESET_PLL;
            cnt_d    = '0;
            retry_d  = '0;
            loss_evt = 1'b0;
        end

        // outputs are decoded from the next state so they register alongside it
        pll_rst_d    = (state_d == RESET_PLL) || (state_d == FAULT);
        all_locked_d = (state_d == RUN);
        fault_d      = (state_d == FAULT);
        dom_d        = '0;
        if (state_d == RUN) begin
            dom_d = '1;
        end else if (state_d == RELEASE) begin
            for (int i = 0; i < NUM_DOMAINS; i++)
                dom_d[i] = (int'(cnt_d) >= i * RELEASE_GAP);
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RESET_PLL;
            cnt          <= '0;
            retry_count  <= '0;
            pll_rst      <= '1;
            domain_rst_n <= '0;
            all_locked   <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            retry_count  <= retry_d;
            pll_rst      <= {NUM_PLL{pll_rst_d}};
            domain_rst_n <= dom_d;
            all_locked   <= all_locked_d;
            fault        <= fault_d;
        end
    end

`ifdef CLK_RST_SEQUENCER_LOSS_CNT_EN
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n)
            lock_loss_cnt <= '0;
        else if (loss_evt && lock_loss_cnt != 16'hFFFF)
            lock_loss_cnt <= lock_loss_cnt + 16'd1;
    end
`else
    logic unused_loss;
    assign unused_loss = loss_evt;
`endif

endmodule

// File: doc/clk_rst_sequencer.md
Name: clk_rst_sequencer

Overview:
Parametrised PLL lock supervisor and reset sequencer that sits between one or more PLL instances and the clock-domain logic of the Computer_System. It drives the PLL reset inputs and synchronises and qualifies their asynchronous locked outputs. It releases per-domain resets in a fixed staggered order, and re-sequences on lock loss, with a bounded retry count and a fault flag.

Parameters:
- NUM_PLL, 2, number of supervised PLLs (1..8).
- NUM_DOMAINS, 4, number of sequenced domain resets (1..16).
- PLL_RST_CYCLES, 16, pll_rst assertion length in refclk cycles (>=1).
- LOCK_STABLE_CYCLES, 1024, consecutive all-locked cycles required before release (>=1).
- LOCK_TIMEOUT_CYCLES, 65536, maximum wait for lock before a retry (>LOCK_STABLE_CYCLES).
- RELEASE_GAP, 8, cycles between successive domain reset releases (>=1).
- MAX_RETRIES, 3, failed lock attempts before FAULT (1..15).

Ports:
- refclk  in  1  single clock for the whole block.
- rst_n  in  1  asynchronous active-low reset.
- pll_locked  in  NUM_PLL  asynchronous PLL locked outputs.
- force_relock  in  1  synchronous single-cycle request to restart the sequence.
- pll_rst  out  NUM_PLL  active-high PLL resets; all bits are always driven identically.
- domain_rst_n  out  NUM_DOMAINS  active-low domain resets; bit i is released i-th.
- all_locked  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- retry_count  out  4  failed lock attempts in the current sequence.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pll_rst=all 1; domain_rst_n=all 0; all_locked=0; fault=0; retry_count=0.
  - Synchronisers are cleared; state=RESET_PLL with counter=0.
- Lock synchronisation: each pll_locked bit passes a 2-flop synchroniser (2-cycle latency). lk = AND of the synchronised bits.
- All outputs are registered.
- RESET_PLL:
  - pll_rst=1 for exactly PLL_RST_CYCLES cycles; domain_rst_n=all 0.
  - Then go to WAIT_LOCK with the timeout counter cleared.
- WAIT_LOCK:
  - pll_rst=0.
  - lk=1 → go to STABLE with the stable counter cleared.
  - Timeout counter reaches LOCK_TIMEOUT_CYCLES → retry_count++. If retry_count then equals MAX_RETRIES → FAULT, else → RESET_PLL.
- STABLE:
  - Count consecutive lk=1 cycles; reaching LOCK_STABLE_CYCLES → RELEASE.
  - lk=0 → back to WAIT_LOCK; the stable counter clears and the timeout counter restarts.
- RELEASE:
  - domain_rst_n[0] deasserts on the RELEASE entry cycle.
  - Bit i deasserts i*RELEASE_GAP cycles later.
  - One cycle after the last bit is released → RUN.
  - lk=0 → all domain_rst_n return to 0 on the next edge; → RESET_PLL.
- RUN:
  - all_locked=1.
  - lk=0 → all_locked=0 and domain_rst_n=all 0 on the next edge; → RESET_PLL; retry_count cleared.
- FAULT: pll_rst=1, domain_rst_n=all 0, fault=1. Held until rst_n or force_relock.
- force_relock:
  - In any state it forces RESET_PLL on the next edge: retry_count=0, fault=0, domain resets asserted.
  - It has priority over every other transition in the same cycle.
- Simultaneous events in WAIT_LOCK: lk rising in the timeout cycle → STABLE wins and no retry is counted.
- Counter widths are derived with $clog2 of the relevant parameter + 1. No counter wraps; each holds at its terminal value until the state changes.
- retry_count saturates at 15.

Optional Feature:
- Macro: CLK_RST_SEQUENCER_LOSS_CNT_EN.
- Defined:
  - Extra output lock_loss_cnt [15:0] counts RUN→RESET_PLL transitions caused by lk=0; force_relock does not count.
  - Saturates at 16'hFFFF; cleared only by rst_n.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package clk_rst_sequencer_pkg:
  - State enum: RESET_PLL, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT.
  - Counter-width helper function.
  - Retry-count width constant, 4.
- Sub-module sync_2ff: 1-bit 2-flop synchroniser with asynchronous active-low clear, instantiated NUM_PLL times.

Test Plan:
Common bench parameters: NUM_PLL=2, NUM_DOMAINS=4, PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, RELEASE_GAP=2, MAX_RETRIES=2.
1. Nominal bring-up: release rst_n; raise both locked 3 cycles after pll_rst falls. Expect:
   - pll_rst high for exactly 4 cycles.
   - domain_rst_n bits released at +0/+2/+4/+6 after stable count 8.
   - all_locked=1 one cycle after the last release.
2. Timeout/fault: hold pll_locked=2'b01. Expect:
   - Two 32-cycle waits, then retry_count=2 and fault=1.
   - pll_rst=2'b11 and domain_rst_n=0 held in FAULT.
3. Lock glitch in STABLE: drop pll_locked[1] for 1 cycle after 5 stable cycles. Expect:
   - The stable counter restarts.
   - Release occurs 8 cycles after the relock, not earlier.
4. Lock loss in RUN: drop pll_locked[0]. Expect:
   - all_locked=0 and domain_rst_n=4'b0000 three edges later (2 sync + 1 registered).
   - pll_rst pulse of 4 cycles; retry_count=0.
   - With the macro defined, lock_loss_cnt=1.
5. force_relock in the same cycle as RELEASE completion → RESET_PLL entered, all_locked stays 0.
   force_relock in FAULT → fault=0, new sequence begins.
6. Asynchronous rst_n assertion mid-RELEASE → all outputs reach reset values without a clock edge. The sequence restarts cleanly on deassertion.
